// File: rtl/mem_responder_if.sv
// ----------------------------------------------------------------------------
// mem_responder_if
// Request/response bundle between a multicycle datapath and mem_responder.
//   req    : access request (master -> slave)
//   we     : 1 = write, 0 = read, qualified by req
//   addr   : 16-bit word address
//   wdata  : 16-bit write data
//   rdata  : registered read data, held until the next ack (slave -> master)
//   ack    : one-cycle completion pulse
//   err    : out-of-range flag, valid only with ack
//   busy   : responder not in IDLE
//   state  : FSM debug view (IDLE=0, WAIT=1, RESP=2)
// Modports: master (datapath side), slave (responder side).
// ----------------------------------------------------------------------------
interface mem_responder_if;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        ack;
    logic        err;
    logic        busy;
    logic [1:0]  state;

    modport master (
        output req, we, addr, wdata,
        input  rdata, ack, err, busy, state
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, ack, err, busy, state
    );
endinterface

// File: rtl/mem_responder.sv
// ----------------------------------------------------------------------------
// mem_responder
// Single-port 2**ADDR_W x 16-bit word memory that answers one request at a
// time through an IDLE -> (WAIT) -> RESP handshake.
//   clk  : single clock, rising edge
//   nrst : asynchronous active-low reset (control/output registers only;
//          memory contents are never reset)
//   bus  : mem_responder_if.slave (req/we/addr/wdata in,
//          rdata/ack/err/busy/state out)
// Parameters:
//   ADDR_W      : log2 of memory depth in words
//   WAIT_CYCLES : wait states between acceptance and response
// Optional feature macro: MEM_WAIT_EN
//   defined   -> WAIT state plus down-counter; ack WAIT_CYCLES+1 edges after
//                the request is presented
//   undefined -> IDLE goes straight to RESP; WAIT_CYCLES is unused
// ----------------------------------------------------------------------------
module mem_responder #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic           clk,
    input  logic           nrst,
    mem_responder_if.slave bus
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } state_e;

`ifdef MEM_WAIT_EN
    localparam bit          UseWait = (WAIT_CYCLES > 0);
    // Counter holds WAIT_CYCLES-1 down to 0, one WAIT cycle per value.
    localparam int unsigned CntW    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLoad =
        CntW'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

    logic [CntW-1:0] r_cnt;
`endif

    state_e            r_state;
    state_e            w_state_d;

    logic [15:0]       r_addr;
    logic [15:0]       r_wdata;
    logic              r_we;
    logic [15:0]       r_rdata;
    logic              r_err;
    logic [15:0]       r_mem [Depth];

    logic              w_accept;
    logic              w_enter_resp;
    logic              w_acc_we;
    logic [15:0]       w_acc_addr;
    logic [15:0]       w_acc_wdata;
    logic              w_oor;
    logic [ADDR_W-1:0] w_idx;
    logic              w_mem_we;
    logic              w_ack;

    // In IDLE the live inputs are the access (no-wait path enters RESP on the
    // accept edge); elsewhere the captured copy is used so mid-access input
    // changes are ignored.
    assign w_accept     = (r_state == StIdle) && bus.req;
    assign w_acc_we     = (r_state == StIdle) ? bus.we    : r_we;
    assign w_acc_addr   = (r_state == StIdle) ? bus.addr  : r_addr;
    assign w_acc_wdata  = (r_state == StIdle) ? bus.wdata : r_wdata;
    assign w_oor        = (w_acc_addr[15:ADDR_W] != '0);
    assign w_idx        = w_acc_addr[ADDR_W-1:0];
    // RESP always exits to IDLE, so a RESP next-state only occurs on entry.
    assign w_enter_resp = (w_state_d == StResp);
    // nrst gate: a req held high during reset would otherwise look like an
    // IDLE->RESP write to the reset-less memory.
    assign w_mem_we     = nrst && w_enter_resp && w_acc_we && !w_oor;

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_state_d = StIdle;
        case (r_state)
            StIdle: begin
                if (bus.req) begin
`ifdef MEM_WAIT_EN
                    w_state_d = UseWait ? StWait : StResp;
`else
                    w_state_d = StResp;
`endif
                end else begin
                    w_state_d = StIdle;
                end
            end
            StWait: begin
`ifdef MEM_WAIT_EN
                w_state_d = (r_cnt == '0) ? StResp : StWait;
`else
                w_state_d = StIdle;
`endif
            end
            StResp:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // ------------------------------------------------- request / response
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_rdata <= '0;
            r_err   <= 1'b0;
`ifdef MEM_WAIT_EN
            r_cnt   <= '0;
`endif
        end else begin
            if (w_accept) begin
                r_addr  <= bus.addr;
                r_wdata <= bus.wdata;
                r_we    <= bus.we;
            end
`ifdef MEM_WAIT_EN
            if (w_accept) begin
                r_cnt <= CntLoad;
            end else if ((r_state == StWait) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
`endif
            if (w_enter_resp) begin
                r_err <= w_oor;
                if (w_oor) begin
                    r_rdata <= '0;
                end else if (!w_acc_we) begin
                    r_rdata <= r_mem[w_idx];
                end
            end
        end
    end

    // Memory array: intentionally no reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_idx] <= w_acc_wdata;
        end
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        w_ack     = (r_state == StResp);
        bus.ack   = w_ack;
        bus.err   = w_ack && r_err;
        bus.busy  = (r_state != StIdle);
        bus.state = r_state;
        bus.rdata = r_rdata;
    end

endmodule

// File: tb/tb_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_mem_responder
// Self-checking bench for mem_responder (ADDR_W=8, WAIT_CYCLES=2). Works with
// MEM_WAIT_EN defined or undefined; expected latency follows the macro.
// ----------------------------------------------------------------------------
module tb_mem_responder;

    localparam int unsigned WC = 2;
`ifdef MEM_WAIT_EN
    localparam int unsigned LAT = (WC > 0) ? WC + 1 : 1;
`else
    localparam int unsigned LAT = 1;
`endif
    localparam int unsigned PER = LAT + 1;

    logic clk;
    logic nrst;

    mem_responder_if bus ();

    mem_responder #(
        .ADDR_W      (8),
        .WAIT_CYCLES (WC)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: word memory, which words are known, held rdata.
    logic [15:0] model_mem [256];
    bit          model_known [256];
    logic [7:0]  known_q [$];
    logic [15:0] model_rdata = 16'h0000;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        exp_err;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic model_apply(input logic we, input logic [15:0] addr, input logic [15:0] wdata);
        logic [7:0] a;
        a = addr[7:0];
        if (addr[15:8] != 8'h00) begin
            model_rdata = 16'h0000;
        end else if (we) begin
            model_mem[a] = wdata;
            if (!model_known[a]) begin
                model_known[a] = 1'b1;
                known_q.push_back(a);
            end
        end else begin
            model_rdata = model_mem[a];
        end
    endtask

    // One access from IDLE; inputs are scrambled while the access is in flight.
    task automatic do_access(input string name, input logic we, input logic [15:0] addr,
                             input logic [15:0] wdata, input logic exp_err,
                             input logic [15:0] exp_rdata);
        bit seen;
        seen      = 1'b0;
        bus.req   = 1'b1;
        bus.we    = we;
        bus.addr  = addr;
        bus.wdata = wdata;
        for (int k = 1; k <= int'(LAT) + 3 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (bus.ack) begin
                seen    = 1'b1;
                bus.req = 1'b0;
                check({name, " latency"}, 16'(k), 16'(LAT));
                check({name, " err"}, 16'(bus.err), 16'(exp_err));
                check({name, " rdata"}, bus.rdata, exp_rdata);
            end else begin
                bus.req   = 1'($urandom);
                bus.we    = 1'($urandom);
                bus.addr  = {8'h00, 8'($urandom)};
                bus.wdata = 16'($urandom);
            end
        end
        if (!seen) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s timeout: no ack within %0d cycles", name, LAT + 3);
        end
        bus.req = 1'b0;
        @(posedge clk);
        #1;
        check({name, " back to idle"}, 16'(bus.state), 16'd0);
    endtask

    task automatic model_access(input string name, input logic we, input logic [15:0] addr,
                                input logic [15:0] wdata);
        logic        e_err;
        logic [15:0] e_rd;
        e_err = (addr[15:8] != 8'h00);
        e_rd  = e_err ? 16'h0000 : (we ? model_rdata : model_mem[addr[7:0]]);
        do_access(name, we, addr, wdata, e_err, e_rd);
        model_apply(we, addr, wdata);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, " state"}, 16'(bus.state), 16'd0);
        check({name, " ack"}, 16'(bus.ack), 16'd0);
        check({name, " err"}, 16'(bus.err), 16'd0);
        check({name, " busy"}, 16'(bus.busy), 16'd0);
        check({name, " rdata"}, bus.rdata, 16'h0000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 16'h0005, 16'hBEEF, 1'b0, 16'h0000};
        vecs[1]  = '{1'b0, 16'h0005, 16'h0000, 1'b0, 16'hBEEF};
        vecs[2]  = '{1'b1, 16'h0000, 16'h1357, 1'b0, 16'hBEEF};
        vecs[3]  = '{1'b0, 16'h0100, 16'h0000, 1'b1, 16'h0000};
        vecs[4]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h1357};
        vecs[5]  = '{1'b1, 16'h0003, 16'h00A5, 1'b0, 16'h1357};
        vecs[6]  = '{1'b0, 16'h0003, 16'h0000, 1'b0, 16'h00A5};
        vecs[7]  = '{1'b1, 16'hFF03, 16'hDEAD, 1'b1, 16'h0000};
        vecs[8]  = '{1'b0, 16'h0003, 16'h0000, 1'b0, 16'h00A5};
        vecs[9]  = '{1'b1, 16'h00FF, 16'h7E7E, 1'b0, 16'h00A5};
        vecs[10] = '{1'b0, 16'h00FF, 16'h0000, 1'b0, 16'h7E7E};

        // Reset held with req high: outputs stay in reset state.
        nrst      = 1'b0;
        bus.req   = 1'b1;
        bus.we    = 1'b0;
        bus.addr  = 16'h0005;
        bus.wdata = 16'h0000;
        #1;
        check_reset_outputs("reset t0");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_reset_outputs($sformatf("reset cyc%0d", i));
        end
        bus.req = 1'b0;
        nrst    = 1'b1;

        // Directed vector table; first access lands on the first edge after reset.
        for (int i = 0; i < 11; i++) begin
            do_access($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
                      vecs[i].exp_err, vecs[i].exp_rdata);
            model_apply(vecs[i].we, vecs[i].addr, vecs[i].wdata);
        end

        // Reset with a write request pending in IDLE must not touch memory.
        bus.req   = 1'b1;
        bus.we    = 1'b1;
        bus.addr  = 16'h0005;
        bus.wdata = 16'h5555;
        nrst      = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_reset_outputs($sformatf("rst wr-req cyc%0d", i));
        end
        bus.req     = 1'b0;
        nrst        = 1'b1;
        model_rdata = 16'h0000;
        model_access("read after rst", 1'b0, 16'h0005, 16'h0000);

        // Reset pulsed right after accepting a write.
        model_access("wr 0010", 1'b1, 16'h0010, 16'h0000);
        bus.req   = 1'b1;
        bus.we    = 1'b1;
        bus.addr  = 16'h0010;
        bus.wdata = 16'h1234;
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        check("pending state", 16'(bus.state), (LAT > 1) ? 16'd1 : 16'd2);
        nrst = 1'b0;
        #1;
        check("async rst state", 16'(bus.state), 16'd0);
        check("async rst busy", 16'(bus.busy), 16'd0);
        check("async rst rdata", bus.rdata, 16'h0000);
        #1;
        nrst        = 1'b1;
        model_rdata = 16'h0000;
        // Without wait states the write already committed on the accept edge.
        if (LAT == 1) model_mem[8'h10] = 16'h1234;
        model_access("rd 0010 after drop", 1'b0, 16'h0010, 16'h0000);

        // req held high for 12 cycles: one access per PER cycles.
        bus.req  = 1'b1;
        bus.we   = 1'b0;
        bus.addr = 16'h0005;
        for (int k = 1; k <= 12; k++) begin
            int m;
            @(posedge clk);
            #1;
            m = k % int'(PER);
            check($sformatf("b2b ack k%0d", k), 16'(bus.ack), (m == int'(LAT)) ? 16'd1 : 16'd0);
            check($sformatf("b2b busy k%0d", k), 16'(bus.busy), (m != 0) ? 16'd1 : 16'd0);
            check($sformatf("b2b state k%0d", k), 16'(bus.state),
                  (m == 0) ? 16'd0 : ((m == int'(LAT)) ? 16'd2 : 16'd1));
            if (m == int'(LAT)) check($sformatf("b2b rdata k%0d", k), bus.rdata, 16'hBEEF);
        end
        bus.req = 1'b0;
        model_rdata = 16'hBEEF;
        @(posedge clk);
        #1;

        // Randomised accesses against the model.
        for (int i = 0; i < 40; i++) begin
            int unsigned r;
            logic [15:0] a;
            logic        w;
            r = $urandom_range(0, 7);
            if (r == 0) begin
                a = {8'($urandom_range(1, 255)), 8'($urandom)};
                w = 1'($urandom);
            end else if (known_q.size() == 0 || r < 4) begin
                a = {8'h00, 8'($urandom)};
                w = 1'b1;
            end else begin
                a = {8'h00, known_q[$urandom_range(0, known_q.size() - 1)]};
                w = 1'b0;
            end
            model_access($sformatf("rand%0d", i), w, a, 16'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
